// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: source classes, pending entry, FSM states.
// Class ordering is numeric so that "outranks" is a plain magnitude compare.
package fetch_redirect_ctrl_pkg;

    localparam int                      REDIR_PC_W   = 32;
    localparam logic [REDIR_PC_W-1:0]   RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        SRC_IF3 = 2'd0,
        SRC_BRU = 2'd1,
        SRC_EXC = 2'd2
    } redirect_src_t;

    typedef struct packed {
        logic [REDIR_PC_W-1:0] pc;
        redirect_src_t         src;
    } redirect_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PEND    = 2'd2,
        ST_WAIT_DS = 2'd3
    } fetch_redir_state_t;

    // IF3 corrections keep the delay slot already sitting in IF3.
    function automatic logic src_keeps_ds(input redirect_src_t src);
        return src == SRC_IF3;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational three-way redirect pick: exception over branch-resolve over IF3 predecode.
// Zero latency, no state; losers are simply not reported.
module redirect_prio_sel
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic                  excp_valid_i,
    input  logic [REDIR_PC_W-1:0] excp_pc_i,
    input  logic                  bru_valid_i,
    input  logic [REDIR_PC_W-1:0] bru_pc_i,
    input  logic                  if3_valid_i,
    input  logic [REDIR_PC_W-1:0] if3_pc_i,
    output logic                  win_valid_o,
    output redirect_entry_t       win_o
);

    always_comb begin
        win_valid_o = excp_valid_i | bru_valid_i | if3_valid_i;
        win_o       = '{pc: if3_pc_i, src: SRC_IF3};
        if (excp_valid_i) begin
            win_o = '{pc: excp_pc_i, src: SRC_EXC};
        end else if (bru_valid_i) begin
            win_o = '{pc: bru_pc_i, src: SRC_BRU};
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect controller: holds one pending redirect, issues a registered strobe the cycle after a PEND cycle with fetch_ready_i.
// Stalls on fetch_ready_i=0 and around unfetched delay slots; optional counters under REDIRECT_PERF_EN.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int               PC_W       = REDIR_PC_W,
    parameter logic [PC_W-1:0]  RESET_PC   = PC_W'(RESET_PC_DEF),
    parameter int               NUM_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  excp_valid_i,
    input  logic [PC_W-1:0]       excp_pc_i,
    input  logic                  bru_valid_i,
    input  logic [PC_W-1:0]       bru_pc_i,
    input  logic                  bru_need_ds_i,
    input  logic                  ds_fetched_i,
    input  logic                  if3_valid_i,
    input  logic [PC_W-1:0]       if3_pc_i,
    input  logic                  fetch_ready_i,
    output logic                  redirect_valid_o,
    output logic [PC_W-1:0]       redirect_pc_o,
    output logic [NUM_STAGES-1:0] flush_if_o,
    output logic                  busy_o
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0]           perf_redirects_o,
    output logic [31:0]           perf_dropped_o,
    output logic [31:0]           perf_ds_wait_o
`endif
);

    fetch_redir_state_t    state_q, state_d;
    redirect_entry_t       entry_q, entry_d;
    redirect_entry_t       win, boot_entry;
    logic                  win_valid;
    logic                  win_need_ds;
    logic                  accept;
    logic                  issue;
    logic                  redirect_valid_q;
    logic [PC_W-1:0]       redirect_pc_q;
    logic [NUM_STAGES-1:0] flush_q;
    logic                  busy_q;

    function automatic logic [NUM_STAGES-1:0] flush_vec(input redirect_src_t src);
        logic [NUM_STAGES-1:0] v;
        v = '1;
        if (src_keeps_ds(src)) begin
            v[NUM_STAGES-1] = 1'b0;
        end
        return v;
    endfunction

    redirect_prio_sel u_prio (
        .excp_valid_i (excp_valid_i),
        .excp_pc_i    (REDIR_PC_W'(excp_pc_i)),
        .bru_valid_i  (bru_valid_i),
        .bru_pc_i     (REDIR_PC_W'(bru_pc_i)),
        .if3_valid_i  (if3_valid_i),
        .if3_pc_i     (REDIR_PC_W'(if3_pc_i)),
        .win_valid_o  (win_valid),
        .win_o        (win)
    );

    assign boot_entry  = '{pc: REDIR_PC_W'(RESET_PC), src: SRC_EXC};
    assign win_need_ds = bru_need_ds_i && (win.src == SRC_BRU);

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // Boot entry behaves as an already-latched exception.
                entry_d = boot_entry;
                state_d = ST_PEND;
                accept  = win_valid && (win.src >= SRC_EXC);
            end
            ST_IDLE: begin
                accept = win_valid;
            end
            ST_PEND: begin
                if (fetch_ready_i) begin
                    if (win_valid && (win.src > entry_q.src)) begin
                        accept = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = ST_IDLE;
                        accept  = win_valid;
                    end
                end else begin
                    accept = win_valid && (win.src >= entry_q.src);
                end
            end
            ST_WAIT_DS: begin
                if (ds_fetched_i) begin
                    state_d = ST_PEND;
                end
                accept = win_valid && (win.src >= entry_q.src);
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // A freshly latched mispredict with its delay slot still upstream must wait for it.
        if (accept) begin
            entry_d = win;
            state_d = win_need_ds ? ST_WAIT_DS : ST_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            entry_q          <= '{pc: '0, src: SRC_IF3};
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= '0;
            busy_q           <= 1'b1;
        end else begin
            state_q          <= state_d;
            entry_q          <= entry_d;
            redirect_valid_q <= issue;
            if (issue) begin
                redirect_pc_q <= PC_W'(entry_q.pc);
            end
            flush_q          <= issue ? flush_vec(entry_q.src) : '0;
            busy_q           <= (state_d != ST_IDLE);
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_if_o       = flush_q;
    assign busy_o           = busy_q;

`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_redirects_q;
    logic [31:0] perf_dropped_q;
    logic [31:0] perf_ds_wait_q;
    logic [1:0]  req_cnt;
    logic [1:0]  drop_cnt;

    // Every request that is not latched this cycle counts as dropped.
    assign req_cnt  = {1'b0, excp_valid_i} + {1'b0, bru_valid_i} + {1'b0, if3_valid_i};
    assign drop_cnt = req_cnt - {1'b0, accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects_q <= '0;
            perf_dropped_q   <= '0;
            perf_ds_wait_q   <= '0;
        end else begin
            perf_redirects_q <= sat_add32(perf_redirects_q, {1'b0, issue});
            perf_dropped_q   <= sat_add32(perf_dropped_q, drop_cnt);
            perf_ds_wait_q   <= sat_add32(perf_ds_wait_q, {1'b0, state_q == ST_WAIT_DS});
        end
    end

    assign perf_redirects_o = perf_redirects_q;
    assign perf_dropped_o   = perf_dropped_q;
    assign perf_ds_wait_o   = perf_ds_wait_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table followed by randomized traffic against a pending-slot model.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        excp_valid, bru_valid, bru_need_ds, ds_fetched, if3_valid, fetch_ready;
    logic [31:0] excp_pc, bru_pc, if3_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  flush_if;
    logic        busy;
`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_redirects, perf_dropped, perf_ds_wait;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .excp_valid_i     (excp_valid),
        .excp_pc_i        (excp_pc),
        .bru_valid_i      (bru_valid),
        .bru_pc_i         (bru_pc),
        .bru_need_ds_i    (bru_need_ds),
        .ds_fetched_i     (ds_fetched),
        .if3_valid_i      (if3_valid),
        .if3_pc_i         (if3_pc),
        .fetch_ready_i    (fetch_ready),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .flush_if_o       (flush_if),
        .busy_o           (busy)
`ifdef REDIRECT_PERF_EN
        ,
        .perf_redirects_o (perf_redirects),
        .perf_dropped_o   (perf_dropped),
        .perf_ds_wait_o   (perf_ds_wait)
`endif
    );

    typedef struct {
        logic        ev;  logic [31:0] ep;
        logic        bv;  logic [31:0] bp; logic bds;
        logic        ds;
        logic        iv;  logic [31:0] ip;
        logic        fr;
        logic        xv;  logic [31:0] xp; logic [2:0] xf; logic xb;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic ev, input logic [31:0] ep, input logic bv, input logic [31:0] bp,
                       input logic bds, input logic ds, input logic iv, input logic [31:0] ip,
                       input logic fr, input logic xv, input logic [31:0] xp, input logic [2:0] xf,
                       input logic xb);
        vec_t v;
        v = '{ev: ev, ep: ep, bv: bv, bp: bp, bds: bds, ds: ds, iv: iv, ip: ip, fr: fr,
              xv: xv, xp: xp, xf: xf, xb: xb};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic ev, input logic [31:0] ep, input logic bv, input logic [31:0] bp,
                         input logic bds, input logic ds, input logic iv, input logic [31:0] ip,
                         input logic fr);
        excp_valid = ev; excp_pc = ep;
        bru_valid = bv; bru_pc = bp; bru_need_ds = bds;
        ds_fetched = ds;
        if3_valid = iv; if3_pc = ip;
        fetch_ready = fr;
    endtask

    task automatic check(input string name, input logic xv, input logic [31:0] xp,
                         input logic [2:0] xf, input logic xb);
        tests++;
        if (redirect_valid !== xv || redirect_pc !== xp || flush_if !== xf || busy !== xb) begin
            fails++;
            $display("FAIL %s: got vld=%b pc=%h flush=%b busy=%b, want vld=%b pc=%h flush=%b busy=%b",
                     name, redirect_valid, redirect_pc, flush_if, busy, xv, xp, xf, xb);
        end
    endtask

`ifdef REDIRECT_PERF_EN
    task automatic check_perf(input string name, input int r, input int d, input int w);
        tests++;
        if (perf_redirects !== 32'(r) || perf_dropped !== 32'(d) || perf_ds_wait !== 32'(w)) begin
            fails++;
            $display("FAIL %s: got redirects=%0d dropped=%0d ds_wait=%0d, want %0d %0d %0d",
                     name, perf_redirects, perf_dropped, perf_ds_wait, r, d, w);
        end
    endtask
`endif

    // Reference model state: one optional pending redirect.
    int          m_pend, m_cls, m_wait, win, nreq, acc;
    logic [31:0] m_pc, m_last;
    int          m_red, m_drop, m_wait_cnt;
    logic        m_issue;
    logic [2:0]  m_flush;

    initial begin
        // Reset release and boot redirect.
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h0,        3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'hBFC00000, 3'b111, 0);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'hBFC00000, 3'b000, 0);
        // Three simultaneous sources: exception wins alone.
        row(1,32'h80000180, 1,32'h80001000,0, 0, 1,32'h80002000, 1,  0,32'hBFC00000, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000180, 3'b111, 0);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000180, 3'b000, 0);
        // IF3 pending under stall, replaced by branch-resolve.
        row(0,0, 0,0,0, 0, 1,32'h80000040, 0,  0,32'h80000180, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 0,  0,32'h80000180, 3'b000, 1);
        row(0,0, 1,32'h80000100,0, 0, 0,0, 0,  0,32'h80000180, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 0,  0,32'h80000180, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000100, 3'b111, 0);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000100, 3'b000, 0);
        // Mispredict waiting on its delay slot.
        row(0,0, 1,32'h80000200,1, 0, 0,0, 1,  0,32'h80000100, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000100, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000100, 3'b000, 1);
        row(0,0, 0,0,0, 1, 0,0, 1,  0,32'h80000100, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000200, 3'b111, 0);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000200, 3'b000, 0);
        // Exception pre-empts the delay-slot wait; stale ds pulse ignored.
        row(0,0, 1,32'h80000300,1, 0, 0,0, 1,  0,32'h80000200, 3'b000, 1);
        row(1,32'h80000180, 0,0,0, 0, 0,0, 0,  0,32'h80000200, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000180, 3'b111, 0);
        row(0,0, 0,0,0, 1, 0,0, 1,  0,32'h80000180, 3'b000, 0);
        // IF3 redirect keeps the IF3 stage.
        row(0,0, 0,0,0, 0, 1,32'h80000400, 1,  0,32'h80000180, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000400, 3'b011, 0);
        // Lower-class request dropped while pending.
        row(0,0, 1,32'h80000500,0, 0, 0,0, 0,  0,32'h80000400, 3'b000, 1);
        row(0,0, 0,0,0, 0, 1,32'h80000600, 0,  0,32'h80000400, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000500, 3'b111, 0);
        // Equal-class request in the issue cycle: back-to-back redirects.
        row(0,0, 0,0,0, 0, 1,32'h80000700, 0,  0,32'h80000500, 3'b000, 1);
        row(0,0, 0,0,0, 0, 1,32'h80000800, 1,  1,32'h80000700, 3'b011, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000800, 3'b011, 0);
        // Outranking request cancels the issue.
        row(0,0, 0,0,0, 0, 1,32'h80000900, 0,  0,32'h80000800, 3'b000, 1);
        row(1,32'h80000A00, 0,0,0, 0, 0,0, 1,  0,32'h80000800, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000A00, 3'b111, 0);
        row(0,0, 0,0,0, 0, 0,0, 1,  0,32'h80000A00, 3'b000, 0);
        // IF3 request during delay-slot wait is dropped.
        row(0,0, 1,32'h80000B00,1, 0, 0,0, 1,  0,32'h80000A00, 3'b000, 1);
        row(0,0, 0,0,0, 0, 1,32'h80000C00, 1,  0,32'h80000A00, 3'b000, 1);
        row(0,0, 0,0,0, 1, 0,0, 1,  0,32'h80000A00, 3'b000, 1);
        row(0,0, 0,0,0, 0, 0,0, 1,  1,32'h80000B00, 3'b111, 0);

        rst = 1'b1;
        drive(0,0, 0,0,0, 0, 0,0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", 1'b0, 32'h0, 3'b000, 1'b1);
`ifdef REDIRECT_PERF_EN
        check_perf("perf_reset", 0, 0, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(tbl[i].ev, tbl[i].ep, tbl[i].bv, tbl[i].bp, tbl[i].bds, tbl[i].ds,
                  tbl[i].iv, tbl[i].ip, tbl[i].fr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].xv, tbl[i].xp, tbl[i].xf, tbl[i].xb);
`ifdef REDIRECT_PERF_EN
            if (i == 5) check_perf("perf_simul", 2, 2, 0);
`endif
        end
`ifdef REDIRECT_PERF_EN
        check_perf("perf_table", 11, 4, 6);
`endif

        m_pend = 0; m_cls = 0; m_wait = 0;
        m_pc = 32'h0; m_last = 32'h80000B00;
        m_red = 11; m_drop = 4; m_wait_cnt = 6;

        for (int c = 0; c < 2000; c++) begin
            logic [31:0] pcs [3];
            logic        rq [3];
            logic        nds, dsf, fr;
            for (int k = 0; k < 3; k++) begin
                rq[k]  = ($urandom_range(0, 3) == 0);
                pcs[k] = $urandom & 32'hFFFF_FFFC;
            end
            nds = $urandom_range(0, 1) == 1;
            dsf = $urandom_range(0, 3) == 0;
            fr  = $urandom_range(0, 1) == 1;
            @(negedge clk);
            drive(rq[2], pcs[2], rq[1], pcs[1], nds, dsf, rq[0], pcs[0], fr);

            // Classes: 2 = exception, 1 = branch resolve, 0 = IF3.
            win = -1; nreq = 0;
            for (int k = 2; k >= 0; k--) begin
                if (rq[k]) begin
                    nreq++;
                    if (win < 0) win = k;
                end
            end
            if (m_pend != 0 && m_wait != 0) m_wait_cnt++;
            m_issue = (m_pend != 0) && (m_wait == 0) && fr && !(win >= 0 && win > m_cls);
            m_flush = 3'b000;
            if (m_issue) begin
                m_red++;
                m_pend  = 0;
                m_last  = m_pc;
                m_flush = (m_cls == 0) ? 3'b011 : 3'b111;
            end
            if (m_pend != 0 && m_wait != 0 && dsf) m_wait = 0;
            acc = (win >= 0 && (m_pend == 0 || win >= m_cls)) ? 1 : 0;
            m_drop += nreq - acc;
            if (acc != 0) begin
                m_pend = 1;
                m_pc   = pcs[win];
                m_cls  = win;
                m_wait = (win == 1 && nds) ? 1 : 0;
            end

            @(posedge clk);
            #1;
            check($sformatf("rand%0d", c), m_issue, m_last, m_flush, m_pend != 0);
        end
`ifdef REDIRECT_PERF_EN
        check_perf("perf_rand", m_red, m_drop, m_wait_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Central redirect controller for the fetch front end (IF1–IF3).
- Arbitrates redirect requests from three sources: commit exceptions, backend branch-resolve mispredicts, and IF3 predecode corrections.
- Holds a pending redirect while fetch cannot accept it, sequences backend mispredicts around an unfetched delay slot, and drives the per-stage flush vector plus the new fetch PC into IF1.

Parameters:
- PC_W, 32, PC width.
- RESET_PC, 32'hBFC0_0000, first fetch PC after reset.
- NUM_STAGES, 3, number of front-end stages flushed by the flush vector (bit 0 = IF1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- excp_valid  in  1  exception/ERET redirect from commit
- excp_pc  in  PC_W  exception target
- bru_valid  in  1  backend branch mispredict
- bru_pc  in  PC_W  corrected target
- bru_need_ds  in  1  delay slot of the mispredicted branch not yet past IF3
- ds_fetched  in  1  pulse: delay-slot instruction left IF3 valid
- if3_valid  in  1  IF3 predecode redirect
- if3_pc  in  PC_W  IF3 redirect target
- fetch_ready  in  1  IF1 can load a new PC this cycle
- redirect_valid  out  1  one-cycle redirect strobe to IF1
- redirect_pc  out  PC_W  redirect target
- flush_if  out  NUM_STAGES  per-stage flush, valid with redirect_valid
- busy  out  1  redirect pending or waiting for delay slot

Behaviour:
- Priority: excp > bru > if3. Same-cycle requests resolve to the single highest-priority source.
- Class of pending entry: EXC=2, BRU=1, IF3=0.
- States: BOOT, IDLE, PEND, WAIT_DS. All outputs are registered.
- Reset:
  - state=BOOT; redirect_valid=0; redirect_pc=0; flush_if=0; busy=1.
  - Reset has priority over every request and clears any pending entry.
- BOOT: loads pending={RESET_PC, EXC class}, then goes to PEND.
- IDLE, winning request at cycle N:
  - If it is bru with bru_need_ds=1: latch it and go to WAIT_DS; no flush issued.
  - Otherwise: latch it and go to PEND.
- PEND:
  - When fetch_ready=1, assert redirect_valid=1 for exactly one cycle (N+1 at the earliest) with the latched pc and flush vector, then go to IDLE.
  - While fetch_ready=0, hold the entry.
- Overwrite rule in PEND/WAIT_DS:
  - A new request with class >= the latched class replaces the entry.
  - A lower-class request is dropped.
  - An equal-class replacement takes the younger (new) request.
- WAIT_DS:
  - On ds_fetched=1, go to PEND; the redirect can issue the next cycle.
  - An excp arrival replaces the entry and goes straight to PEND.
  - if3 requests are dropped.
  - In this state, IF3 flush requests are also suppressed: flush_if stays 0 until the redirect issues.
- flush_if encoding:
  - EXC/BRU: all ones.
  - IF3: bits [NUM_STAGES-2:0] set, IF3 bit clear, so the delay slot survives.
- Request and issue in the same cycle: the issue uses the old entry. The new request is latched for a subsequent issue, unless it outranks the old entry, in which case issue is cancelled that cycle and the new entry is latched.
- busy = (state != IDLE).
- Back-to-back: a request in the issue cycle is accepted, giving a new PEND with no bubble state.

Optional Feature:
- Macro REDIRECT_PERF_EN.
- Defined: adds outputs perf_redirects (32 bits, counts issued redirects), perf_dropped (32 bits, counts dropped lower-priority requests) and perf_ds_wait (32 bits, counts cycles in WAIT_DS). All counters saturate at all ones and are cleared by rst.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Decomposition:
- Shared package (defs): redirect_src_t enum {EXC, BRU, IF3}; RedirectEntry struct {pc, src}; state enum fetch_redir_state_t; constant RESET_PC default.
- One sub-module, redirect_prio_sel: combinational 3-way priority pick producing a RedirectEntry plus a valid bit. The FSM stays in the parent.

Test Plan:
1. Reset release, fetch_ready=1 → redirect_valid pulses 1 cycle, redirect_pc=0xBFC0_0000, flush_if=3'b111; busy=0 after.
2. Same-cycle excp_pc=0x8000_0180, bru_pc=0x8000_1000, if3_pc=0x8000_2000 → a single redirect to 0x8000_0180 with flush 3'b111; bru and if3 requests not issued.
3. if3 request to 0x8000_0040 with fetch_ready=0 for 4 cycles, then bru to 0x8000_0100 in cycle 2 → one redirect to 0x8000_0100 with flush 3'b111 once fetch_ready rises.
4. bru_need_ds=1, target 0x8000_0200; ds_fetched pulses 3 cycles later → no redirect during wait, busy=1; redirect 1 cycle after ds_fetched with flush 3'b111.
5. In WAIT_DS, excp to 0x8000_0180 → redirect to 0x8000_0180 without waiting for ds_fetched; the later ds_fetched is ignored.
6. With REDIRECT_PERF_EN, scenario 2 → perf_redirects=1, perf_dropped=2 (reset redirect included in count: perf_redirects=2).
